// File: rtl/dummy_lzc_drain.sv
// dummy_lzc_drain: captures a request vector and drains it one set bit per
// output handshake, in trailing-zero (MODE=0) or leading-zero (MODE=1) order.
module dummy_lzc_drain #(
  parameter int unsigned WIDTH = 16,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] vec_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [WIDTH-1:0] pending_o,
  output logic [IDX_W:0]   emitted_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [IDX_W:0] EMIT_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_clr;
  logic [IDX_W:0]   emitted_q;
  logic             done_q;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_empty;

  // Priority select over pending bits. Yields the bit position directly, which
  // equals the trailing-zero count for MODE=0 and WIDTH-1-leading-zero count
  // for MODE=1; zero when nothing is pending.
  always_comb begin
    sel_idx   = '0;
    sel_empty = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MODE) begin
        if (pending_q[i]) begin
          sel_idx   = IDX_W'(i);
          sel_empty = 1'b0;
        end
      end else begin
        if (pending_q[WIDTH-1-i]) begin
          sel_idx   = IDX_W'(WIDTH-1-i);
          sel_empty = 1'b0;
        end
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    vec_ready_o = 1'b0;
    idx_valid_o = 1'b0;
    busy_o      = 1'b0;
    pending_clr = pending_q & ~(WIDTH'(1) << sel_idx);
    case (state_q)
      IDLE: begin
        vec_ready_o = 1'b1;
        if (vec_valid_i && (vec_i != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        idx_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (idx_ready_i && (pending_clr == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Vector storage, emit counter and done pulse; reset and clear both abort
  // silently.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      pending_q <= '0;
      emitted_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vec_valid_i) begin
            emitted_q <= '0;
            if (vec_i != '0) begin
              pending_q <= vec_i;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (idx_ready_i) begin
            pending_q <= pending_clr;
            emitted_q <= emitted_q + EMIT_ONE;
            if (pending_clr == '0) begin
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign idx_o     = sel_idx;
  assign pending_o = pending_q;
  assign emitted_o = emitted_q;
  assign done_o    = done_q;

  // A drained vector must never leave DRAIN with nothing selectable.
  a_no_empty_in_drain: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q == DRAIN) |-> !sel_empty
  );

endmodule

// File: tb/tb_dummy_lzc_drain.sv
// Bench for dummy_lzc_drain: two instances (MODE=0 and MODE=1) share stimulus
// and are checked against a queue-based reference model.
module tb_dummy_lzc_drain;

  localparam int unsigned W  = 16;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n, clear, vec_valid, idx_ready;
  logic [W-1:0]  vec;
  logic          vrdy0, vrdy1, ival0, ival1, busy0, busy1, done0, done1;
  logic [IW-1:0] idx0, idx1;
  logic [W-1:0]  pend0, pend1;
  logic [IW:0]   em0, em1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queues of positions still to emit, in each priority order.
  int            q0[$];
  int            q1[$];
  logic [W-1:0]  m_pend0, m_pend1;
  int            m_emitted;
  bit            m_busy, m_done;

  always #5 clk = ~clk;

  dummy_lzc_drain #(.WIDTH(W), .MODE(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .vec_i(vec),
    .vec_valid_i(vec_valid), .vec_ready_o(vrdy0), .idx_o(idx0),
    .idx_valid_o(ival0), .idx_ready_i(idx_ready), .pending_o(pend0),
    .emitted_o(em0), .busy_o(busy0), .done_o(done0)
  );

  dummy_lzc_drain #(.WIDTH(W), .MODE(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .vec_i(vec),
    .vec_valid_i(vec_valid), .vec_ready_o(vrdy1), .idx_o(idx1),
    .idx_valid_o(ival1), .idx_ready_i(idx_ready), .pending_o(pend1),
    .emitted_o(em1), .busy_o(busy1), .done_o(done1)
  );

  // Advance model with the inputs presented for this edge, then clock the DUTs.
  task automatic tick();
    int e0, e1;
    if (!rst_n || clear) begin
      q0.delete(); q1.delete();
      m_pend0 = '0; m_pend1 = '0; m_emitted = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (vec_valid) begin
          m_emitted = 0;
          if (vec != '0) begin
            for (int i = 0; i < W; i++) begin
              if (vec[i]) begin
                q0.push_back(i);
                q1.push_front(i);
              end
            end
            m_pend0 = vec; m_pend1 = vec; m_busy = 1;
          end else begin
            m_done = 1;
          end
        end
      end else if (idx_ready) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        m_pend0[e0] = 1'b0;
        m_pend1[e1] = 1'b0;
        m_emitted++;
        if (q0.size() == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clear = 0; vec = '0; vec_valid = 0; idx_ready = 0;
    tick(); tick();
    rst_n = 1;
    n_tests++;
    if ({vrdy0, vrdy1, ival0, ival1, busy0, busy1, done0, done1} !== 8'b1100_0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 11000000",
               {vrdy0, vrdy1, ival0, ival1, busy0, busy1, done0, done1});
    end
    n_tests++;
    if (idx0 !== 4'd0 || idx1 !== 4'd0 || pend0 !== 16'h0 || pend1 !== 16'h0 ||
        em0 !== 5'd0 || em1 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data got idx %0d/%0d pend %h/%h em %0d/%0d want all 0",
               idx0, idx1, pend0, pend1, em0, em1);
    end
  endtask

  task automatic test_zero_vec();
    vec = 16'h0000; vec_valid = 1;
    tick();
    vec_valid = 0;
    n_tests++;
    if (done0 !== 1'b1 || done1 !== 1'b1 || ival0 !== 1'b0 || vrdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_vec_done got done %b%b ival %b vrdy %b want 11 0 1",
               done0, done1, ival0, vrdy0);
    end
    tick();
    n_tests++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || ival1 !== 1'b0 || vrdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_vec_pulse got done %b%b ival %b vrdy %b want 00 0 1",
               done0, done1, ival1, vrdy1);
    end
  endtask

  task automatic test_mode_order();
    int exp0[4] = '{0, 5, 10, 15};
    int exp1[4] = '{15, 10, 5, 0};
    vec = 16'h8421; vec_valid = 1; idx_ready = 1;
    tick();
    vec_valid = 0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ival0 !== 1'b1 || idx0 !== 4'(exp0[k]) || idx1 !== 4'(exp1[k]) || done0 !== 1'b0) begin
        n_fail++;
        $display("FAIL order_%0d got v%b idx %0d/%0d want v1 idx %0d/%0d",
                 k, ival0, idx0, idx1, exp0[k], exp1[k]);
      end
      tick();
    end
    n_tests++;
    if (done0 !== 1'b1 || done1 !== 1'b1 || em0 !== 5'd4 || em1 !== 5'd4 ||
        vrdy0 !== 1'b1 || ival0 !== 1'b0) begin
      n_fail++;
      $display("FAIL order_done got done %b%b em %0d/%0d vrdy %b ival %b want 11 4/4 1 0",
               done0, done1, em0, em1, vrdy0, ival0);
    end
    idx_ready = 0;
    tick();
  endtask

  task automatic test_stall();
    vec = 16'h0003; vec_valid = 1; idx_ready = 0;
    tick();
    vec_valid = 0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (idx0 !== 4'd0 || idx1 !== 4'd1 || pend0 !== 16'h0003 || pend1 !== 16'h0003 ||
          em0 !== 5'd0 || ival0 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_%0d got idx %0d/%0d pend %h/%h em %0d want 0/1 0003 0",
                 k, idx0, idx1, pend0, pend1, em0);
      end
      tick();
    end
    idx_ready = 1;
    tick();
    n_tests++;
    if (idx0 !== 4'd1 || idx1 !== 4'd0 || pend0 !== 16'h0002 || pend1 !== 16'h0001 ||
        em1 !== 5'd1) begin
      n_fail++;
      $display("FAIL stall_release got idx %0d/%0d pend %h/%h em %0d want 1/0 0002/0001 1",
               idx0, idx1, pend0, pend1, em1);
    end
    tick();
    n_tests++;
    if (done0 !== 1'b1 || em0 !== 5'd2) begin
      n_fail++;
      $display("FAIL stall_done got done %b em %0d want 1 2", done0, em0);
    end
    idx_ready = 0;
    tick();
  endtask

  task automatic test_clear();
    vec = 16'hFFFF; vec_valid = 1; idx_ready = 1;
    tick();
    vec_valid = 0;
    repeat (5) tick();
    clear = 1;
    tick();
    n_tests++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || pend0 !== 16'h0 || pend1 !== 16'h0 ||
        em0 !== 5'd0 || done0 !== 1'b0 || vrdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_drain got busy %b%b pend %h/%h em %0d done %b vrdy %b want 00 0/0 0 0 1",
               busy0, busy1, pend0, pend1, em0, done0, vrdy0);
    end
    // clear in IDLE suppresses an offered vector
    vec = 16'h0010; vec_valid = 1;
    tick();
    clear = 0; vec_valid = 0;
    n_tests++;
    if (busy0 !== 1'b0 || ival1 !== 1'b0 || pend0 !== 16'h0 || done0 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle got busy %b ival %b pend %h done %b%b want 0 0 0000 00",
               busy0, ival1, pend0, done0, done1);
    end
    tick();
  endtask

  task automatic test_full();
    vec = 16'hFFFF; vec_valid = 1; idx_ready = 1;
    tick();
    vec_valid = 0;
    repeat (15) tick();
    n_tests++;
    if (busy0 !== 1'b1 || idx0 !== 4'd15 || idx1 !== 4'd0 || em0 !== 5'd15) begin
      n_fail++;
      $display("FAIL full_last got busy %b idx %0d/%0d em %0d want 1 15/0 15",
               busy0, idx0, idx1, em0);
    end
    tick();
    n_tests++;
    if (done0 !== 1'b1 || done1 !== 1'b1 || em0 !== 5'd16 || em1 !== 5'd16) begin
      n_fail++;
      $display("FAIL full_done got done %b%b em %0d/%0d want 11 16/16", done0, done1, em0, em1);
    end
    idx_ready = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    vec = 16'h0001; vec_valid = 1; idx_ready = 1;
    tick();
    vec = 16'h0100;
    n_tests++;
    if (ival0 !== 1'b1 || idx0 !== 4'd0 || vrdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first got ival %b idx %0d vrdy %b want 1 0 0", ival0, idx0, vrdy0);
    end
    tick();
    n_tests++;
    if (ival0 !== 1'b0 || vrdy0 !== 1'b1 || done0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_bubble got ival %b vrdy %b done %b want 0 1 1", ival0, vrdy0, done0);
    end
    tick();
    vec_valid = 0;
    n_tests++;
    if (ival1 !== 1'b1 || idx0 !== 4'd8 || idx1 !== 4'd8 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second got ival %b idx %0d/%0d done %b want 1 8/8 0",
               ival1, idx0, idx1, done0);
    end
    tick();
    n_tests++;
    if (done0 !== 1'b1 || done1 !== 1'b1 || ival0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done2 got done %b%b ival %b want 11 0", done0, done1, ival0);
    end
    idx_ready = 0;
    tick();
  endtask

  task automatic test_random();
    logic [IW-1:0] e0, e1;
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      clear     = ($urandom_range(0, 29) == 0);
      vec_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       vec = '0;
        1:       vec = 16'($urandom);
        default: vec = 16'($urandom & $urandom & $urandom);
      endcase
      idx_ready = ($urandom_range(0, 3) != 0);
      tick();
      e0 = (q0.size() != 0) ? 4'(q0[0]) : 4'd0;
      e1 = (q1.size() != 0) ? 4'(q1[0]) : 4'd0;
      n_tests++;
      if (ival0 !== m_busy || ival1 !== m_busy || busy0 !== m_busy || vrdy0 !== !m_busy ||
          vrdy1 !== !m_busy || done0 !== m_done || done1 !== m_done ||
          idx0 !== e0 || idx1 !== e1 || pend0 !== m_pend0 || pend1 !== m_pend1 ||
          em0 !== 5'(m_emitted) || em1 !== 5'(m_emitted)) begin
        n_fail++;
        $display("FAIL rand_%0d got v%b%b d%b%b idx %0d/%0d pend %h/%h em %0d/%0d want v%b d%b idx %0d/%0d pend %h/%h em %0d",
                 c, ival0, ival1, done0, done1, idx0, idx1, pend0, pend1, em0, em1,
                 m_busy, m_done, e0, e1, m_pend0, m_pend1, m_emitted);
      end
    end
    rst_n = 1; clear = 0; vec_valid = 0; idx_ready = 0;
  endtask

  initial begin
    test_reset();
    test_zero_vec();
    test_mode_order();
    test_stall();
    test_clear();
    test_full();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

endmodule
